vdp_cpu_port: RTL and testbench

- Z80-facing side of the VDP. Decodes CPU accesses to the data port (0xBE) and the control port (0xBF).
- Maintains the 14-bit address register, the 2-bit code register, the 2-byte command latch and the read-ahead buffer.
- Writes VRAM, CRAM and the 11 mode registers that the display pipeline consumes; services VRAM reads into the read buffer.
- VRAM is accessed only while the display pipeline reports screenBusy=0. A one-entry pending-operation slot holds CPU requests until then.

---
 rtl/vdp_cpu_port.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_vdp_cpu_port.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_cpu_port.sv
// -----------------------------------------------------------------------------
// vdp_cpu_port
//
// Z80-facing side of the VDP. Decodes CPU accesses to the data port (0xBE,
// cpu_port=0) and the control port (0xBF, cpu_port=1). Holds the 14-bit
// address register, the 2-bit code register, the two-byte command latch and
// the read-ahead buffer. Writes CRAM and the mode registers directly. VRAM
// traffic goes through a one-entry pending slot that waits for the display
// pipeline to release VRAM (screenBusy=0).
//
// Ports:
//   clk, rst_L            clock, asynchronous active-low reset
//   cpu_wr, cpu_rd        one-cycle CPU strobes (both high together = ignored)
//   cpu_port              0 = data port, 1 = control port
//   cpu_din               CPU write data
//   cpu_dout              CPU read data, valid in the cycle after cpu_rd
//   cpu_ready             1 = a data port access will be accepted
//   status_in             status byte from interrupt/sprite logic
//   status_rd             one-cycle pulse after a control port read
//   screenBusy            display pipeline owns VRAM when 1
//   VRAM_CPU_*            VRAM address/data/strobes (read data one cycle later)
//   CRAM_CPU_*            CRAM address/data/write strobe
//   regFile               VDP mode registers
//   fsm_state             current pending-slot state (Idle/WrPend/RdPend/RdCap)
//
// Handshake: cpu_ready is a level, high only while the pending slot is empty.
// A data port strobe seen while cpu_ready=1 is accepted in that cycle; one
// seen while cpu_ready=0 is dropped with no side effects. Control port
// accesses ignore cpu_ready and are always accepted.
// -----------------------------------------------------------------------------
module vdp_cpu_port #(
   parameter int NUM_REGS = 11
) (
   input  logic                     clk,
   input  logic                     rst_L,
   input  logic                     cpu_wr,
   input  logic                     cpu_rd,
   input  logic                     cpu_port,
   input  logic [7:0]               cpu_din,
   output logic [7:0]               cpu_dout,
   output logic                     cpu_ready,
   input  logic [7:0]               status_in,
   output logic                     status_rd,
   input  logic                     screenBusy,
   output logic [13:0]              VRAM_CPU_addr,
   output logic [7:0]               VRAM_CPU_data_in,
   output logic                     VRAM_CPU_we,
   output logic                     VRAM_CPU_re,
   input  logic [7:0]               VRAM_CPU_data_out,
   output logic [4:0]               CRAM_CPU_addr,
   output logic [5:0]               CRAM_CPU_data,
   output logic                     CRAM_CPU_we,
   output logic [NUM_REGS-1:0][7:0] regFile,
   output logic [1:0]               fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WR_PEND = 2'd1,
      S_RD_PEND = 2'd2,
      S_RD_CAP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [13:0] addr_q, addr_d;
   logic [1:0]  code_q;
   logic        second_q;
   logic [7:0]  read_buf_q;
   logic [13:0] pend_addr_q;
   logic [7:0]  pend_data_q;

   // ---------------------------------------------------------------------------
   // Access decode
   // ---------------------------------------------------------------------------
   logic        idle;
   logic        wr_only, rd_only;
   logic        ctrl_wr, ctrl_rd;
   logic        data_wr, data_rd;
   logic        cmd_done;
   logic [1:0]  new_code;
   logic [13:0] cmd_addr;
   logic        cmd_read;
   logic        cmd_reg;
   logic        cram_wr, vram_wr;

   assign idle     = (state_q == S_IDLE);
   // Simultaneous write and read strobes are treated as no access at all.
   assign wr_only  = cpu_wr & ~cpu_rd;
   assign rd_only  = cpu_rd & ~cpu_wr;
   assign ctrl_wr  = wr_only & cpu_port;
   assign ctrl_rd  = rd_only & cpu_port;
   // Data port accesses only count while the pending slot is free.
   assign data_wr  = wr_only & ~cpu_port & idle;
   assign data_rd  = rd_only & ~cpu_port & idle;

   // Second command byte: code in [7:6], address high bits in [5:0].
   assign cmd_done = ctrl_wr & second_q;
   assign new_code = cpu_din[7:6];
   assign cmd_addr = {cpu_din[5:0], addr_q[7:0]};
   // A code-0 command can only start its read-ahead when the slot is free;
   // if an access is still in flight the address is loaded but no read queued.
   assign cmd_read = cmd_done & (new_code == 2'd0) & idle;
   assign cmd_reg  = cmd_done & (new_code == 2'd2);

   assign cram_wr  = data_wr & (code_q == 2'd3);
   assign vram_wr  = data_wr & (code_q != 2'd3);

   // ---------------------------------------------------------------------------
   // Pending-slot FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // VRAM strobes are gated combinationally by screenBusy so that they can
   // never overlap a cycle in which the display pipeline owns VRAM.
   always_comb begin
      state_d     = state_q;
      VRAM_CPU_we = 1'b0;
      VRAM_CPU_re = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (vram_wr) begin
               state_d = S_WR_PEND;
            end else if (data_rd || cmd_read) begin
               state_d = S_RD_PEND;
            end
         end
         S_WR_PEND: begin
            if (!screenBusy) begin
               VRAM_CPU_we = 1'b1;
               state_d     = S_IDLE;
            end
         end
         S_RD_PEND: begin
            if (!screenBusy) begin
               VRAM_CPU_re = 1'b1;
               state_d     = S_RD_CAP;
            end
         end
         // Capture does not touch VRAM, so it finishes regardless of screenBusy.
         S_RD_CAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign cpu_ready        = idle;
   assign fsm_state        = state_q;
   assign VRAM_CPU_addr    = pend_addr_q;
   assign VRAM_CPU_data_in = pend_data_q;

   // ---------------------------------------------------------------------------
   // Address register
   // ---------------------------------------------------------------------------
   // Reads advance the address only once the byte is captured; writes advance
   // it immediately. A command byte landing in the capture cycle overrides the
   // byte of the address it carries.
   always_comb begin
      addr_d = addr_q;
      if (state_q == S_RD_CAP) begin
         addr_d = addr_q + 14'd1;
      end
      if (data_wr) begin
         addr_d = addr_q + 14'd1;
      end
      if (ctrl_wr) begin
         if (!second_q) begin
            addr_d[7:0] = cpu_din;
         end else begin
            addr_d[13:8] = cpu_din[5:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Command latch and code register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         second_q <= 1'b0;
         code_q   <= '0;
      end else begin
         if (ctrl_wr) begin
            second_q <= ~second_q;
         end else if (ctrl_rd || data_wr || data_rd) begin
            second_q <= 1'b0;
         end
         if (cmd_done) begin
            code_q <= new_code;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Pending slot contents
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         pend_addr_q <= '0;
         pend_data_q <= '0;
      end else begin
         if (vram_wr) begin
            pend_addr_q <= addr_q;
            pend_data_q <= cpu_din;
         end else if (data_rd) begin
            pend_addr_q <= addr_q;
         end else if (cmd_read) begin
            pend_addr_q <= cmd_addr;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read-ahead buffer and CPU read data
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         read_buf_q <= '0;
         cpu_dout   <= '0;
         status_rd  <= 1'b0;
      end else begin
         // A data write also refreshes the read-ahead buffer.
         if (data_wr) begin
            read_buf_q <= cpu_din;
         end else if (state_q == S_RD_CAP) begin
            read_buf_q <= VRAM_CPU_data_out;
         end
         if (ctrl_rd) begin
            cpu_dout <= status_in;
         end else if (data_rd) begin
            cpu_dout <= read_buf_q;
         end
         status_rd <= ctrl_rd;
      end
   end

   // ---------------------------------------------------------------------------
   // CRAM write port
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         CRAM_CPU_we   <= 1'b0;
         CRAM_CPU_addr <= '0;
         CRAM_CPU_data <= '0;
      end else begin
         CRAM_CPU_we <= cram_wr;
         if (cram_wr) begin
            CRAM_CPU_addr <= addr_q[4:0];
            CRAM_CPU_data <= cpu_din[5:0];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Mode registers. The value is the first command byte, still held in
   // addr_q[7:0] while the second byte is being accepted. Indices past the
   // implemented set match no entry and are dropped.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         regFile <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_reg && (int'(cpu_din[3:0]) == i)) begin
               regFile[i] <= addr_q[7:0];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Structural invariants of the VRAM interface
   // ---------------------------------------------------------------------------
   a_no_we_re_overlap : assert property (@(posedge clk) disable iff (!rst_L)
      !(VRAM_CPU_we && VRAM_CPU_re));
   a_no_strobe_busy   : assert property (@(posedge clk) disable iff (!rst_L)
      !(screenBusy && (VRAM_CPU_we || VRAM_CPU_re)));

endmodule

// File: tb/tb_vdp_cpu_port.sv
module tb_vdp_cpu_port;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic             clk = 1'b0;
   logic             rst_L;
   logic             cpu_wr, cpu_rd, cpu_port;
   logic [7:0]       cpu_din, cpu_dout;
   logic             cpu_ready;
   logic [7:0]       status_in;
   logic             status_rd;
   logic             screenBusy;
   logic [13:0]      VRAM_CPU_addr;
   logic [7:0]       VRAM_CPU_data_in;
   logic             VRAM_CPU_we, VRAM_CPU_re;
   logic [7:0]       VRAM_CPU_data_out;
   logic [4:0]       CRAM_CPU_addr;
   logic [5:0]       CRAM_CPU_data;
   logic             CRAM_CPU_we;
   logic [10:0][7:0] regFile;
   logic [1:0]       fsm_state;

   always #5 clk = ~clk;

   vdp_cpu_port #(.NUM_REGS(11)) dut (
      .clk               (clk),
      .rst_L             (rst_L),
      .cpu_wr            (cpu_wr),
      .cpu_rd            (cpu_rd),
      .cpu_port          (cpu_port),
      .cpu_din           (cpu_din),
      .cpu_dout          (cpu_dout),
      .cpu_ready         (cpu_ready),
      .status_in         (status_in),
      .status_rd         (status_rd),
      .screenBusy        (screenBusy),
      .VRAM_CPU_addr     (VRAM_CPU_addr),
      .VRAM_CPU_data_in  (VRAM_CPU_data_in),
      .VRAM_CPU_we       (VRAM_CPU_we),
      .VRAM_CPU_re       (VRAM_CPU_re),
      .VRAM_CPU_data_out (VRAM_CPU_data_out),
      .CRAM_CPU_addr     (CRAM_CPU_addr),
      .CRAM_CPU_data     (CRAM_CPU_data),
      .CRAM_CPU_we       (CRAM_CPU_we),
      .regFile           (regFile),
      .fsm_state         (fsm_state)
   );

   // ---------------------------------------------------------------------------
   // VRAM array behind the port: read data appears the cycle after the strobe
   // ---------------------------------------------------------------------------
   logic [7:0] mem [16384];

   always @(posedge clk) begin
      if (VRAM_CPU_re) VRAM_CPU_data_out <= mem[VRAM_CPU_addr];
      if (VRAM_CPU_we) mem[VRAM_CPU_addr] = VRAM_CPU_data_in;
   end

   // ---------------------------------------------------------------------------
   // Counters and checker
   // ---------------------------------------------------------------------------
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model of the port as the CPU sees it
   // ---------------------------------------------------------------------------
   logic [13:0] m_addr;
   logic [1:0]  m_code;
   bit          m_second;
   logic [7:0]  m_read_buf;
   logic [7:0]  m_regs [11];
   logic [7:0]  mdl_mem [16384];
   logic [21:0] exp_wq [$];   // {addr, data} of expected VRAM writes
   logic [10:0] exp_cq [$];   // {addr, data} of expected CRAM writes

   task automatic mdl_reset();
      m_addr     = '0;
      m_code     = '0;
      m_second   = 1'b0;
      m_read_buf = '0;
      for (int i = 0; i < 11; i++) m_regs[i] = '0;
      exp_wq.delete();
      exp_cq.delete();
   endtask

   task automatic mdl_ctrl_write(input logic [7:0] b);
      if (!m_second) begin
         m_addr[7:0] = b;
         m_second    = 1'b1;
      end else begin
         m_code       = b[7:6];
         m_addr[13:8] = b[5:0];
         m_second     = 1'b0;
         if (m_code == 2'd2) begin
            for (int i = 0; i < 11; i++)
               if (int'(b[3:0]) == i) m_regs[i] = m_addr[7:0];
         end
         if (m_code == 2'd0) begin
            m_read_buf = mdl_mem[m_addr];
            m_addr     = m_addr + 14'd1;
         end
      end
   endtask

   task automatic mdl_data_write(input logic [7:0] b);
      if (m_code == 2'd3) begin
         exp_cq.push_back({m_addr[4:0], b[5:0]});
      end else begin
         exp_wq.push_back({m_addr, b});
         mdl_mem[m_addr] = b;
      end
      m_read_buf = b;
      m_addr     = m_addr + 14'd1;
      m_second   = 1'b0;
   endtask

   task automatic mdl_data_read();
      m_read_buf = mdl_mem[m_addr];
      m_addr     = m_addr + 14'd1;
      m_second   = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Compare process: runs every cycle on the falling edge
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      logic [21:0] ew;
      logic [10:0] ec;
      check("vram_we_re_overlap", {31'd0, VRAM_CPU_we & VRAM_CPU_re}, 32'd0);
      check("vram_strobe_while_busy", {31'd0, screenBusy & (VRAM_CPU_we | VRAM_CPU_re)}, 32'd0);
      if (VRAM_CPU_we) begin
         if (exp_wq.size() == 0) begin
            check("vram_we_unexpected", {18'd0, VRAM_CPU_addr}, 32'hFFFF_FFFF);
         end else begin
            ew = exp_wq.pop_front();
            check("vram_write", {10'd0, VRAM_CPU_addr, VRAM_CPU_data_in}, {10'd0, ew});
         end
      end
      if (CRAM_CPU_we) begin
         if (exp_cq.size() == 0) begin
            check("cram_we_unexpected", {27'd0, CRAM_CPU_addr}, 32'hFFFF_FFFF);
         end else begin
            ec = exp_cq.pop_front();
            check("cram_write", {21'd0, CRAM_CPU_addr, CRAM_CPU_data}, {21'd0, ec});
         end
      end
      for (int i = 0; i < 11; i++)
         check($sformatf("regFile[%0d]", i), {24'd0, regFile[i]}, {24'd0, m_regs[i]});
   end

   // ---------------------------------------------------------------------------
   // Driver tasks: each starts and ends 1 time unit after a rising edge
   // ---------------------------------------------------------------------------
   task automatic wait_ready();
      for (int k = 0; k < 200; k++) begin
         if (cpu_ready) break;
         @(posedge clk); #1;
      end
      if (!cpu_ready) check("cpu_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic bus(input logic wr, input logic rd, input logic port, input logic [7:0] d);
      cpu_wr   = wr;
      cpu_rd   = rd;
      cpu_port = port;
      cpu_din  = d;
      @(posedge clk); #1;
      cpu_wr   = 1'b0;
      cpu_rd   = 1'b0;
   endtask

   task automatic ctrl_write(input logic [7:0] b);
      bus(1'b1, 1'b0, 1'b1, b);
      mdl_ctrl_write(b);
   endtask

   task automatic data_write(input logic [7:0] b);
      wait_ready();
      bus(1'b1, 1'b0, 1'b0, b);
      mdl_data_write(b);
   endtask

   task automatic data_read();
      logic [7:0] e;
      wait_ready();
      e = m_read_buf;
      bus(1'b0, 1'b1, 1'b0, 8'h00);
      check("data_read_dout", {24'd0, cpu_dout}, {24'd0, e});
      mdl_data_read();
   endtask

   task automatic ctrl_read();
      bus(1'b0, 1'b1, 1'b1, 8'h00);
      m_second = 1'b0;
      check("status_rd_pulse", {31'd0, status_rd}, 32'd1);
      check("ctrl_read_dout", {24'd0, cpu_dout}, {24'd0, status_in});
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      rst_L      = 1'b0;
      cpu_wr     = 1'b0;
      cpu_rd     = 1'b0;
      cpu_port   = 1'b0;
      cpu_din    = 8'h00;
      status_in  = 8'hA5;
      screenBusy = 1'b0;
      mdl_reset();
      for (int i = 0; i < 16384; i++) begin
         mem[i]     = 8'(i * 7 + 3);
         mdl_mem[i] = mem[i];
      end
      mem[14'h1000] = 8'h34; mdl_mem[14'h1000] = 8'h34;
      mem[14'h1001] = 8'h56; mdl_mem[14'h1001] = 8'h56;

      repeat (3) @(posedge clk);
      #1;
      // Reset state
      check("rst_cpu_dout",   {24'd0, cpu_dout}, 32'd0);
      check("rst_cpu_ready",  {31'd0, cpu_ready}, 32'd1);
      check("rst_status_rd",  {31'd0, status_rd}, 32'd0);
      check("rst_strobes",    {29'd0, VRAM_CPU_we, VRAM_CPU_re, CRAM_CPU_we}, 32'd0);
      check("rst_regfile0",   {24'd0, regFile[0]}, 32'd0);
      rst_L = 1'b1;
      @(posedge clk); #1;

      // Register writes, including out-of-range indices
      ctrl_write(8'h8C); ctrl_write(8'h81);
      check("reg1_lit", {24'd0, regFile[1]}, 32'h8C);
      ctrl_write(8'h55); ctrl_write(8'h8F);
      check("reg1_after_idx15", {24'd0, regFile[1]}, 32'h8C);
      ctrl_write(8'h77); ctrl_write(8'h8A);
      check("reg10_lit", {24'd0, regFile[10]}, 32'h77);
      ctrl_write(8'h66); ctrl_write(8'h8B);

      // Simultaneous read and write strobes do nothing
      bus(1'b1, 1'b1, 1'b1, 8'h33);
      ctrl_write(8'h44); ctrl_write(8'h84);
      check("reg4_after_collision", {24'd0, regFile[4]}, 32'h44);

      // VRAM write burst with VRAM free
      ctrl_write(8'h00); ctrl_write(8'h7F);
      data_write(8'hAA);
      check("burst_we_latency", {31'd0, VRAM_CPU_we}, 32'd1);
      check("burst_first_addr", {18'd0, VRAM_CPU_addr}, 32'h3F00);
      check("burst_ready_low",  {31'd0, cpu_ready}, 32'd0);
      data_write(8'hBB);
      data_write(8'hCC);
      check("model_addr_burst", {18'd0, m_addr}, 32'h3F03);

      // Deferred write while the display owns VRAM
      wait_ready();
      ctrl_write(8'h00); ctrl_write(8'h41);
      screenBusy = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      data_write(8'h12);
      check("deferred_ready_low", {31'd0, cpu_ready}, 32'd0);
      bus(1'b1, 1'b0, 1'b0, 8'h99);          // dropped: slot occupied
      check("dropped_ready_low", {31'd0, cpu_ready}, 32'd0);
      repeat (15) begin @(posedge clk); #1; end
      check("busy_no_we", {31'd0, VRAM_CPU_we}, 32'd0);
      screenBusy = 1'b0;
      #1;
      check("deferred_we", {31'd0, VRAM_CPU_we}, 32'd1);
      check("deferred_addr_data", {10'd0, VRAM_CPU_addr, VRAM_CPU_data_in}, {10'd0, 14'h0100, 8'h12});
      @(posedge clk); #1;
      check("deferred_we_one_cycle", {31'd0, VRAM_CPU_we}, 32'd0);
      data_write(8'h21);                     // must land at 0x0101
      check("model_addr_after_drop", {18'd0, m_addr}, 32'h0102);

      // Read-ahead
      wait_ready();
      ctrl_write(8'h00); ctrl_write(8'h10);
      data_read();
      check("read_first_lit", {24'd0, cpu_dout}, 32'h34);
      data_read();
      check("read_second_lit", {24'd0, cpu_dout}, 32'h56);

      // CRAM write at the top of the address space, then wrap
      wait_ready();
      ctrl_write(8'hFF); ctrl_write(8'hFF);
      data_write(8'h3F);
      check("cram_we_lit", {31'd0, CRAM_CPU_we}, 32'd1);
      check("cram_addr_data_lit", {21'd0, CRAM_CPU_addr, CRAM_CPU_data}, {21'd0, 5'h1F, 6'h3F});
      check("cram_no_vram", {30'd0, VRAM_CPU_we, VRAM_CPU_re}, 32'd0);
      check("cram_ready_high", {31'd0, cpu_ready}, 32'd1);
      data_write(8'h05);
      check("cram_wrap_addr", {27'd0, CRAM_CPU_addr}, 32'h00);

      // Control read clears the half-written command
      ctrl_write(8'h20);
      ctrl_read();
      @(posedge clk); #1;
      check("status_rd_one_cycle", {31'd0, status_rd}, 32'd0);
      ctrl_write(8'h5A); ctrl_write(8'h82);
      check("reg2_after_latch_clear", {24'd0, regFile[2]}, 32'h5A);

      // Reset in the middle of a deferred write
      wait_ready();
      ctrl_write(8'h00); ctrl_write(8'h45);
      screenBusy = 1'b1;
      data_write(8'h77);
      @(posedge clk); #1;
      rst_L = 1'b0;
      mdl_reset();
      repeat (2) begin @(posedge clk); #1; end
      rst_L      = 1'b1;
      screenBusy = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      check("post_reset_ready", {31'd0, cpu_ready}, 32'd1);
      check("post_reset_reg1", {24'd0, regFile[1]}, 32'd0);

      // Everything the model expected has been seen
      check("vram_queue_drained", exp_wq.size(), 32'd0);
      check("cram_queue_drained", exp_cq.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
